// File: rtl/echo_delay_ctrl.sv
// Echo delay-line sequencer: for each accepted sample, reads the delayed tap from a
// single-port ring-buffer RAM, writes the new sample, and emits dry + attenuated tap saturated.
module echo_delay_ctrl #(
  parameter int unsigned ADDR_W  = 16,
  parameter int unsigned DATA_W  = 16,
  parameter int unsigned RAM_LAT = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              enable,
  input  logic [ADDR_W-1:0] delay_len,
  input  logic [2:0]        mix_shift,
  input  logic              sample_in_valid,
  input  logic [DATA_W-1:0] sample_in,
  output logic              busy,
  output logic              drop,
  output logic              sample_out_valid,
  output logic [DATA_W-1:0] sample_out,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_d,
  output logic              ram_we,
  input  logic [DATA_W-1:0] ram_q
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_READ,
    S_WAIT,
    S_CAPTURE,
    S_WRITE,
    S_OUTPUT
  } state_t;

  localparam logic [1:0] WAIT_LAST = 2'((RAM_LAT > 1) ? (RAM_LAT - 2) : 0);
  localparam logic [DATA_W-1:0] SAT_MAX = {1'b0, {(DATA_W-1){1'b1}}};
  localparam logic [DATA_W-1:0] SAT_MIN = {1'b1, {(DATA_W-1){1'b0}}};

  state_t state_q, state_d;

  logic [1:0]        wait_cnt_q, wait_cnt_d;
  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0] fill_cnt_q, fill_cnt_d;
  logic [ADDR_W-1:0] dly_q, dly_d;
  logic [2:0]        shift_q, shift_d;
  logic              en_q, en_d;
  logic [DATA_W-1:0] smp_q, smp_d;
  logic [DATA_W-1:0] tap_q, tap_d;
  logic              busy_q, busy_d;
  logic              drop_q, drop_d;
  logic              out_valid_q, out_valid_d;
  logic [DATA_W-1:0] out_q, out_d;
  logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
  logic [DATA_W-1:0] ram_d_q, ram_d_d;
  logic              ram_we_q, ram_we_d;

  logic signed [DATA_W-1:0] tap_sh;
  logic [DATA_W:0]          mix_sum;
  logic [DATA_W-1:0]        mix_sat;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:    if (sample_in_valid) state_d = S_READ;
      S_READ:    state_d = (RAM_LAT > 1) ? S_WAIT : S_CAPTURE;
      S_WAIT:    if (wait_cnt_q == WAIT_LAST) state_d = S_CAPTURE;
      S_CAPTURE: state_d = S_WRITE;
      S_WRITE:   state_d = S_OUTPUT;
      S_OUTPUT:  state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  // Mix is one sign bit wider than the sample so overflow shows as a sign-bit disagreement.
  always_comb begin
    tap_sh  = $signed(tap_q) >>> shift_q;
    mix_sum = {smp_q[DATA_W-1], smp_q} + {tap_sh[DATA_W-1], tap_sh};
    if (mix_sum[DATA_W] != mix_sum[DATA_W-1]) begin
      mix_sat = mix_sum[DATA_W] ? SAT_MIN : SAT_MAX;
    end else begin
      mix_sat = mix_sum[DATA_W-1:0];
    end
  end

  always_comb begin
    wait_cnt_d  = wait_cnt_q;
    wr_ptr_d    = wr_ptr_q;
    fill_cnt_d  = fill_cnt_q;
    dly_d       = dly_q;
    shift_d     = shift_q;
    en_d        = en_q;
    smp_d       = smp_q;
    tap_d       = tap_q;
    out_d       = out_q;
    ram_addr_d  = ram_addr_q;
    ram_d_d     = ram_d_q;
    ram_we_d    = 1'b0;
    out_valid_d = 1'b0;
    busy_d      = (state_d != S_IDLE);
    drop_d      = sample_in_valid && (state_q != S_IDLE);
    case (state_q)
      S_IDLE: begin
        if (sample_in_valid) begin
          smp_d      = sample_in;
          dly_d      = delay_len;
          shift_d    = mix_shift;
          en_d       = enable;
          ram_addr_d = wr_ptr_q - delay_len;
        end
      end
      S_READ: begin
        wait_cnt_d = '0;
      end
      S_WAIT: begin
        wait_cnt_d = wait_cnt_q + 2'd1;
      end
      S_CAPTURE: begin
        // Until the ring holds delay_len samples the read slot is stale history.
        tap_d      = ((dly_q != '0) && (fill_cnt_q >= dly_q)) ? ram_q : '0;
        ram_addr_d = wr_ptr_q;
        ram_d_d    = smp_q;
        ram_we_d   = 1'b1;
      end
      S_WRITE: begin
        wr_ptr_d    = wr_ptr_q + 1'b1;
        fill_cnt_d  = (fill_cnt_q != '1) ? (fill_cnt_q + 1'b1) : fill_cnt_q;
        out_d       = en_q ? mix_sat : smp_q;
        out_valid_d = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wait_cnt_q  <= '0;
      wr_ptr_q    <= '0;
      fill_cnt_q  <= '0;
      dly_q       <= '0;
      shift_q     <= '0;
      en_q        <= 1'b0;
      smp_q       <= '0;
      tap_q       <= '0;
      busy_q      <= 1'b0;
      drop_q      <= 1'b0;
      out_valid_q <= 1'b0;
      out_q       <= '0;
      ram_addr_q  <= '0;
      ram_d_q     <= '0;
      ram_we_q    <= 1'b0;
    end else begin
      wait_cnt_q  <= wait_cnt_d;
      wr_ptr_q    <= wr_ptr_d;
      fill_cnt_q  <= fill_cnt_d;
      dly_q       <= dly_d;
      shift_q     <= shift_d;
      en_q        <= en_d;
      smp_q       <= smp_d;
      tap_q       <= tap_d;
      busy_q      <= busy_d;
      drop_q      <= drop_d;
      out_valid_q <= out_valid_d;
      out_q       <= out_d;
      ram_addr_q  <= ram_addr_d;
      ram_d_q     <= ram_d_d;
      ram_we_q    <= ram_we_d;
    end
  end

  assign busy             = busy_q;
  assign drop             = drop_q;
  assign sample_out_valid = out_valid_q;
  assign sample_out       = out_q;
  assign ram_addr         = ram_addr_q;
  assign ram_d            = ram_d_q;
  assign ram_we           = ram_we_q;

endmodule

// File: tb/tb_echo_delay_ctrl.sv
// Directed bench for echo_delay_ctrl: a default instance (16-bit ring, RAM_LAT=1) and a
// small instance (4-bit ring, RAM_LAT=2) each backed by a behavioural RAM.
module tb_echo_delay_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                rst_n;
  logic                enable;
  logic [15:0]         delay_len;
  logic [2:0]          mix_shift;
  logic                sample_in_valid;
  logic signed [15:0]  sample_in;

  logic                busy, drop, sample_out_valid, ram_we;
  logic signed [15:0]  sample_out;
  logic [15:0]         ram_addr, ram_d, ram_q;

  logic                s_busy, s_drop, s_valid, s_we;
  logic signed [15:0]  s_out;
  logic [3:0]          s_addr;
  logic [15:0]         s_d, s_q, s_stage;

  logic [15:0] mem  [65536] = '{default: 16'h1111};
  logic [15:0] smem [16]    = '{default: 16'h1111};

  int tests = 0;
  int fails = 0;

  echo_delay_ctrl #(.ADDR_W(16), .DATA_W(16), .RAM_LAT(1)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .delay_len(delay_len),
    .mix_shift(mix_shift), .sample_in_valid(sample_in_valid), .sample_in(sample_in),
    .busy(busy), .drop(drop), .sample_out_valid(sample_out_valid), .sample_out(sample_out),
    .ram_addr(ram_addr), .ram_d(ram_d), .ram_we(ram_we), .ram_q(ram_q)
  );

  echo_delay_ctrl #(.ADDR_W(4), .DATA_W(16), .RAM_LAT(2)) dut_small (
    .clk(clk), .rst_n(rst_n), .enable(enable), .delay_len(delay_len[3:0]),
    .mix_shift(mix_shift), .sample_in_valid(sample_in_valid), .sample_in(sample_in),
    .busy(s_busy), .drop(s_drop), .sample_out_valid(s_valid), .sample_out(s_out),
    .ram_addr(s_addr), .ram_d(s_d), .ram_we(s_we), .ram_q(s_q)
  );

  always @(posedge clk) begin
    if (ram_we) mem[ram_addr] <= ram_d;
    ram_q <= mem[ram_addr];
  end

  always @(posedge clk) begin
    if (s_we) smem[s_addr] <= s_d;
    s_stage <= smem[s_addr];
    s_q     <= s_stage;
  end

  task automatic do_reset();
    rst_n = 1'b0;
    sample_in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  // Strobe one sample into the default instance and watch a minimum-spacing window.
  // With mut set, the configuration inputs are scrambled right after acceptance.
  task automatic send(input logic signed [15:0] s, input bit mut,
                      output logic signed [15:0] out, output logic [15:0] rd_a,
                      output logic [15:0] wr_a, output int lat, output int wes);
    sample_in = s;
    sample_in_valid = 1'b1;
    @(posedge clk); #1;
    sample_in_valid = 1'b0;
    if (mut) begin
      enable    = ~enable;
      delay_len = delay_len + 16'd3;
      mix_shift = 3'd7;
      sample_in = 16'sh7FFF;
    end
    out  = 'x;
    wr_a = 'x;
    rd_a = ram_addr;
    lat  = -1;
    wes  = 0;
    for (int c = 1; c <= 4; c++) begin
      if (ram_we) begin
        wes++;
        wr_a = ram_addr;
      end
      if (sample_out_valid && lat < 0) begin
        lat = c;
        out = sample_out;
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset();
    logic [52:0] v;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    v = {busy, drop, sample_out_valid, ram_we, sample_out, ram_addr, ram_d};
    tests++;
    if (v !== '0) begin
      fails++;
      $display("FAIL reset_held outputs got %h exp 0", v);
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
    v = {busy, drop, sample_out_valid, ram_we, sample_out, ram_addr, ram_d};
    tests++;
    if (v !== '0) begin
      fails++;
      $display("FAIL reset_released outputs got %h exp 0", v);
    end
    tests++;
    if ({s_busy, s_valid, s_we, s_addr} !== '0) begin
      fails++;
      $display("FAIL reset_small outputs got %h exp 0", {s_busy, s_valid, s_we, s_addr});
    end
  endtask

  task automatic test_echo();
    logic signed [15:0] exp_o [6];
    logic signed [15:0] out;
    logic [15:0] rd_a, wr_a, exp_rd;
    int lat, wes;
    exp_o[0] = 16'sd1000; exp_o[1] = 16'sd2000; exp_o[2] = 16'sd3000;
    exp_o[3] = 16'sd4000; exp_o[4] = 16'sd5500; exp_o[5] = 16'sd7000;
    enable = 1'b1; delay_len = 16'd4; mix_shift = 3'd1;
    for (int i = 0; i < 6; i++) begin
      send(16'(1000 * (i + 1)), 1'b0, out, rd_a, wr_a, lat, wes);
      exp_rd = 16'(i) - 16'd4;
      tests++;
      if (out !== exp_o[i]) begin
        fails++;
        $display("FAIL echo_out[%0d] got %0d exp %0d", i, out, exp_o[i]);
      end
      tests++;
      if (rd_a !== exp_rd) begin
        fails++;
        $display("FAIL echo_rd_addr[%0d] got %h exp %h", i, rd_a, exp_rd);
      end
      tests++;
      if (wr_a !== 16'(i)) begin
        fails++;
        $display("FAIL echo_wr_addr[%0d] got %h exp %h", i, wr_a, 16'(i));
      end
      tests++;
      if (lat != 4) begin
        fails++;
        $display("FAIL echo_latency[%0d] got %0d exp 4", i, lat);
      end
      tests++;
      if (wes != 1) begin
        fails++;
        $display("FAIL echo_we_count[%0d] got %0d exp 1", i, wes);
      end
    end
  endtask

  task automatic test_saturation();
    logic signed [15:0] out;
    logic [15:0] rd_a, wr_a;
    int lat, wes;
    do_reset();
    enable = 1'b1; delay_len = 16'd1; mix_shift = 3'd0;
    send(16'sd30000, 1'b0, out, rd_a, wr_a, lat, wes);
    tests++;
    if (out !== 16'sd30000) begin
      fails++;
      $display("FAIL sat_pos_first got %0d exp 30000", out);
    end
    send(16'sd30000, 1'b0, out, rd_a, wr_a, lat, wes);
    tests++;
    if (out !== 16'sd32767) begin
      fails++;
      $display("FAIL sat_pos got %0d exp 32767", out);
    end
    do_reset();
    send(-16'sd30000, 1'b0, out, rd_a, wr_a, lat, wes);
    tests++;
    if (out !== -16'sd30000) begin
      fails++;
      $display("FAIL sat_neg_first got %0d exp -30000", out);
    end
    send(-16'sd30000, 1'b0, out, rd_a, wr_a, lat, wes);
    tests++;
    if (out !== -16'sd32768) begin
      fails++;
      $display("FAIL sat_neg got %0d exp -32768", out);
    end
  endtask

  // Ring holds -30000 at 0 and 1 from the saturation test; wr_ptr is 2.
  task automatic test_disable_and_latch();
    logic signed [15:0] out;
    logic [15:0] rd_a, wr_a;
    int lat, wes;
    enable = 1'b0; delay_len = 16'd1; mix_shift = 3'd0;
    send(16'sd100, 1'b0, out, rd_a, wr_a, lat, wes);
    tests++;
    if (out !== 16'sd100) begin
      fails++;
      $display("FAIL dry_pass got %0d exp 100", out);
    end
    send(16'sd200, 1'b1, out, rd_a, wr_a, lat, wes);
    tests++;
    if (out !== 16'sd200) begin
      fails++;
      $display("FAIL dry_latched got %0d exp 200", out);
    end
    enable = 1'b1; delay_len = 16'd1; mix_shift = 3'd2;
    send(16'sd400, 1'b0, out, rd_a, wr_a, lat, wes);
    tests++;
    if (out !== 16'sd450) begin
      fails++;
      $display("FAIL mix_shift2 got %0d exp 450", out);
    end
    send(16'sd800, 1'b1, out, rd_a, wr_a, lat, wes);
    tests++;
    if (out !== 16'sd900) begin
      fails++;
      $display("FAIL mix_latched got %0d exp 900", out);
    end
    enable = 1'b1; delay_len = 16'd1; mix_shift = 3'd2;
    send(-16'sd800, 1'b0, out, rd_a, wr_a, lat, wes);
    tests++;
    if (out !== -16'sd600) begin
      fails++;
      $display("FAIL mix_neg_in got %0d exp -600", out);
    end
    mix_shift = 3'd3;
    send(16'sd0, 1'b0, out, rd_a, wr_a, lat, wes);
    tests++;
    if (out !== -16'sd100) begin
      fails++;
      $display("FAIL mix_neg_tap got %0d exp -100", out);
    end
    delay_len = 16'd0;
    send(16'sd1234, 1'b0, out, rd_a, wr_a, lat, wes);
    tests++;
    if (out !== 16'sd1234) begin
      fails++;
      $display("FAIL zero_delay_out got %0d exp 1234", out);
    end
    tests++;
    if (rd_a !== 16'd8 || wr_a !== 16'd8) begin
      fails++;
      $display("FAIL zero_delay_addr got rd %h wr %h exp 0008 0008", rd_a, wr_a);
    end
  endtask

  task automatic test_overrun();
    int drops, dmask, wes, vcnt, vcyc;
    logic busy1, busy5;
    logic signed [15:0] out;
    do_reset();
    enable = 1'b1; delay_len = 16'd0; mix_shift = 3'd0;
    sample_in = 16'sd111;
    sample_in_valid = 1'b1;
    @(posedge clk); #1;
    sample_in_valid = 1'b0;
    drops = 0; dmask = 0; wes = 0; vcnt = 0; vcyc = -1; out = 'x;
    busy1 = 1'b0; busy5 = 1'b1;
    for (int c = 1; c <= 7; c++) begin
      if (drop) begin
        drops++;
        dmask |= (1 << c);
      end
      if (ram_we) wes++;
      if (sample_out_valid) begin
        vcnt++;
        vcyc = c;
        out = sample_out;
      end
      if (c == 1) busy1 = busy;
      if (c == 5) busy5 = busy;
      sample_in_valid = (c == 2 || c == 4);
      sample_in = 16'sd999;
      @(posedge clk); #1;
    end
    sample_in_valid = 1'b0;
    tests++;
    if (drops != 2 || dmask != 'h28) begin
      fails++;
      $display("FAIL overrun_drop got count %0d mask %h exp 2 28", drops, dmask);
    end
    tests++;
    if (wes != 1) begin
      fails++;
      $display("FAIL overrun_we got %0d exp 1", wes);
    end
    tests++;
    if (vcnt != 1 || vcyc != 4) begin
      fails++;
      $display("FAIL overrun_valid got count %0d cycle %0d exp 1 4", vcnt, vcyc);
    end
    tests++;
    if (out !== 16'sd111) begin
      fails++;
      $display("FAIL overrun_out got %0d exp 111", out);
    end
    tests++;
    if (busy1 !== 1'b1 || busy5 !== 1'b0) begin
      fails++;
      $display("FAIL overrun_busy got %b%b exp 10", busy1, busy5);
    end
  endtask

  task automatic test_reset_mid();
    logic signed [15:0] out;
    logic [15:0] rd_a, wr_a;
    int lat, wes, vcnt;
    enable = 1'b1; delay_len = 16'd1; mix_shift = 3'd0;
    sample_in = 16'sd500;
    sample_in_valid = 1'b1;
    @(posedge clk); #1;
    sample_in_valid = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    tests++;
    if ({busy, ram_we, sample_out_valid} !== 3'b000) begin
      fails++;
      $display("FAIL midreset_outputs got %b exp 000", {busy, ram_we, sample_out_valid});
    end
    @(posedge clk);
    @(posedge clk);
    #1 rst_n = 1'b1;
    vcnt = 0;
    for (int c = 0; c < 4; c++) begin
      if (sample_out_valid || ram_we) vcnt++;
      @(posedge clk); #1;
    end
    tests++;
    if (vcnt != 0) begin
      fails++;
      $display("FAIL midreset_no_result got %0d exp 0", vcnt);
    end
    send(16'sd700, 1'b0, out, rd_a, wr_a, lat, wes);
    tests++;
    if (out !== 16'sd700) begin
      fails++;
      $display("FAIL midreset_next_out got %0d exp 700", out);
    end
    tests++;
    if (wr_a !== 16'd0 || rd_a !== 16'hFFFF) begin
      fails++;
      $display("FAIL midreset_next_addr got wr %h rd %h exp 0000 ffff", wr_a, rd_a);
    end
  endtask

  task automatic test_wrap();
    logic signed [15:0] out, exp_out;
    logic [3:0] wr_a, exp_wr;
    int lat;
    do_reset();
    enable = 1'b1; delay_len = 16'd15; mix_shift = 3'd0;
    for (int k = 1; k <= 20; k++) begin
      sample_in = 16'(k);
      sample_in_valid = 1'b1;
      @(posedge clk); #1;
      sample_in_valid = 1'b0;
      out = 'x; wr_a = 'x; lat = -1;
      for (int c = 1; c <= 5; c++) begin
        if (s_we) wr_a = s_addr;
        if (s_valid && lat < 0) begin
          lat = c;
          out = s_out;
        end
        @(posedge clk); #1;
      end
      exp_out = (k <= 15) ? 16'(k) : 16'(2 * k - 15);
      exp_wr  = 4'((k - 1) % 16);
      tests++;
      if (out !== exp_out) begin
        fails++;
        $display("FAIL wrap_out[%0d] got %0d exp %0d", k, out, exp_out);
      end
      tests++;
      if (wr_a !== exp_wr) begin
        fails++;
        $display("FAIL wrap_wr_addr[%0d] got %h exp %h", k, wr_a, exp_wr);
      end
      tests++;
      if (lat != 5) begin
        fails++;
        $display("FAIL wrap_latency[%0d] got %0d exp 5", k, lat);
      end
    end
  endtask

  initial begin
    rst_n = 1'b0;
    enable = 1'b0;
    delay_len = '0;
    mix_shift = '0;
    sample_in_valid = 1'b0;
    sample_in = '0;
    test_reset();
    test_echo();
    test_saturation();
    test_disable_and_latch();
    test_overrun();
    test_reset_mid();
    test_wrap();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/echo_delay_ctrl.md
# echo_delay_ctrl

Sequencer for the echo path's single-port delay RAM. For each accepted mono sample it reads the delayed tap at `wr_ptr - delay_len` and writes the new sample at `wr_ptr`, in strict read-then-write order. It then outputs the input plus the attenuated tap, saturated to 16 bits. It sits between the audio sample source and the echo output mixer and is the only agent driving the delay RAM.

## Interface
- `ADDR_W`, 16, delay RAM address width; the ring buffer holds 2^ADDR_W samples.
- `DATA_W`, 16, signed sample width.
- `RAM_LAT`, 1, delay RAM read latency in cycles (1..4).
- `clk` in 1: single clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `enable` in 1: 1 = echo mixed in; 0 = dry passthrough, RAM history still written.
- `delay_len` in ADDR_W: echo delay in samples; 0 means no tap.
- `mix_shift` in 3: tap attenuation; the tap is arithmetic-shifted right by this amount.
- `sample_in_valid` in 1: one-cycle strobe, new sample present.
- `sample_in` in DATA_W: signed input sample.
- `busy` out 1: high in every state except IDLE.
- `drop` out 1: one-cycle pulse when a strobe arrives while busy.
- `sample_out_valid` out 1: one-cycle pulse, `sample_out` valid.
- `sample_out` out DATA_W: signed mixed sample; holds its value until the next result.
- `ram_addr` out ADDR_W: delay RAM address.
- `ram_d` out DATA_W: write data to the RAM.
- `ram_we` out 1: write enable, high for exactly one cycle per accepted sample.
- `ram_q` in DATA_W: read data from the RAM, valid RAM_LAT cycles after the address.

## Operation
- Reset: state IDLE. `wr_ptr`, `fill_cnt`, `tap`, `busy`, `drop`, `sample_out_valid`, `sample_out`, `ram_addr`, `ram_d` and `ram_we` are all 0.
- States and transitions:
  - IDLE → READ on `sample_in_valid`. In the same edge, latch `sample_in`, `delay_len`, `mix_shift` and `enable`. Later changes to these inputs do not affect the sample in flight.
  - READ (1 cycle): `ram_addr = wr_ptr - delay_len` mod 2^ADDR_W, `ram_we = 0`.
  - WAIT: RAM_LAT-1 cycles, counted by an internal counter. Skipped when RAM_LAT = 1.
  - CAPTURE (1 cycle): `tap <= ram_q` if `fill_cnt >= delay_len` and `delay_len != 0`, else `tap <= 0`.
  - WRITE (1 cycle): `ram_addr = wr_ptr`, `ram_d = latched sample`, `ram_we = 1`. At the closing edge, `wr_ptr` increments, wrapping 2^ADDR_W-1 → 0. `fill_cnt` increments and saturates at 2^ADDR_W-1.
  - OUTPUT (1 cycle): `sample_out_valid = 1`. Next state is IDLE.
- Mix arithmetic:
  - Enabled: `sample_out = sat16(sample + (tap >>> mix_shift))`. The sum is taken at DATA_W+1 bits and clamped to [-32768, 32767].
  - Disabled (latched `enable = 0`): `sample_out = sample`.
- Overrun: a strobe in any non-IDLE state is ignored. `drop` pulses in the following cycle; there is no RAM access and no state change.
- A strobe in the same cycle the FSM is in OUTPUT is also dropped. A strobe in IDLE is accepted.
- `fill_cnt` starts at 0 after reset, so the first `delay_len` outputs are dry.

## Timing
- All outputs are registered.
- Strobe accepted at edge E0. The FSM is in READ during cycle 1, CAPTURE during cycle 1+RAM_LAT, WRITE during cycle 2+RAM_LAT, and OUTPUT during cycle 3+RAM_LAT.
- Latency from strobe to `sample_out_valid` is 3+RAM_LAT cycles: 4 cycles for RAM_LAT = 1.
- Minimum strobe spacing is 4+RAM_LAT cycles.
- `busy` rises in the cycle after acceptance and falls in the cycle after OUTPUT.
- The read always precedes the write within one sample, so there is no read/write collision on the same address. With `delay_len = 0` the read hits the stale slot and the value is discarded.
- Asynchronous reset mid-operation clears every register immediately:
  - `ram_we` drops combinationally with `rst_n`.
  - A sample whose WRITE edge has not occurred is lost.
  - No `sample_out_valid` is produced.

## Test plan
- Reset with `rst_n = 0` for 3 cycles, then release → all outputs 0, `busy = 0`; the first strobe produces a READ at address `0 - delay_len`.
- Echo: `delay_len = 4`, `mix_shift = 1`, samples 1000, 2000, …, 6000 spaced 5 cycles apart:
  - First 4 outputs equal their inputs.
  - Output 5 = 5000 + 500 = 5500; output 6 = 6000 + 1000 = 7000.
  - The first read address is 0xFFFC; writes go to 0..5.
- Saturation: `delay_len = 1`, `mix_shift = 0`:
  - 30000, 30000 → second output 32767.
  - After reset, -30000, -30000 → second output -32768.
- Overrun: strobe at cycle 0, second strobe at cycle 2 → one `drop` pulse, exactly one `ram_we`, one `sample_out_valid` at cycle 4.
- Wrap: `ADDR_W = 4`, `delay_len = 15`, `mix_shift = 0`, `enable = 1`, inputs 1..20:
  - Write addresses go 15 → 0.
  - Output 16 = 16 + 1 = 17; outputs 1..15 are dry.
- Reset asserted during CAPTURE → `busy`, `ram_we` and `sample_out_valid` are 0 at once. The next sample writes address 0 with a zero tap.
